// File: rtl/usb_fs_rx_frontend_if.sv
// Bundle of the USB full-speed receive front-end signals.
// The front end is the master and the packet decoder is the slave.
interface usb_fs_rx_frontend_if;
    logic       usb_p_rx;
    logic       usb_n_rx;
    logic [1:0] line_state;
    logic       pkt_start;
    logic       bit_strobe;
    logic       bit_data;
    logic       pkt_end;
    logic       rx_err;
    logic       usb_reset_det;

    modport master (
        input  usb_p_rx, usb_n_rx,
        output line_state, pkt_start, bit_strobe, bit_data, pkt_end, rx_err, usb_reset_det
    );

    modport slave (
        output usb_p_rx, usb_n_rx,
        input  line_state, pkt_start, bit_strobe, bit_data, pkt_end, rx_err, usb_reset_det
    );
endinterface

// File: rtl/usb_fs_rx_frontend.sv
// USB full-speed receive front end: line synchronizer, 4x oversampled clock recovery,
// NRZI decode, SYNC/EOP framing, bit-unstuffing and bus-reset detection.
module usb_fs_rx_frontend #(
    parameter int unsigned RESET_CYCLES = 120
) (
    input  logic                  clk_48mhz,
    input  logic                  reset,
    usb_fs_rx_frontend_if.master  bus
);

    localparam int unsigned SE0_W = $clog2(RESET_CYCLES + 1);
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP
    } state_t;

    logic             p_meta, p_sync, n_meta, n_sync;
    logic [1:0]       line_state;
    logic [1:0]       prev_ls;
    logic [1:0]       phase;
    logic             transition;
    logic             sample;
    logic [SE0_W-1:0] se0_cnt;
    logic             reset_det;

    state_t           state, state_n;
    logic             ref_j, ref_j_n;
    logic [2:0]       zero_cnt, zero_cnt_n;
    logic [2:0]       ones_cnt, ones_cnt_n;
    logic             start_q, strobe_q, data_q, end_q, err_q;
    logic             start_n, strobe_n, data_n, end_n, err_n;

    logic             is_j, is_k, is_se0, is_se1, dec_bit;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            p_meta <= 1'b1;
            p_sync <= 1'b1;
            n_meta <= 1'b0;
            n_sync <= 1'b0;
        end else begin
            p_meta <= bus.usb_p_rx;
            p_sync <= p_meta;
            n_meta <= bus.usb_n_rx;
            n_sync <= n_meta;
        end
    end

    assign line_state = {n_sync, p_sync};

    // Phase reloads on each line change so the sample lands mid-bit two clocks later;
    // a sample that would coincide with a new transition is skipped.
    assign transition = (line_state != prev_ls);
    assign sample     = (phase == 2'd2) && !transition;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            prev_ls <= LS_J;
            phase   <= '0;
        end else begin
            prev_ls <= line_state;
            phase   <= transition ? 2'd1 : phase + 2'd1;
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            se0_cnt <= '0;
        end else if (line_state != LS_SE0) begin
            se0_cnt <= '0;
        end else if (se0_cnt != SE0_W'(RESET_CYCLES)) begin
            se0_cnt <= se0_cnt + 1'b1;
        end
    end

    assign reset_det = (se0_cnt == SE0_W'(RESET_CYCLES));

    assign is_j    = (line_state == LS_J);
    assign is_k    = (line_state == LS_K);
    assign is_se0  = (line_state == LS_SE0);
    assign is_se1  = (line_state == LS_SE1);
    assign dec_bit = (is_j == ref_j);

    always_comb begin
        state_n    = state;
        ref_j_n    = ref_j;
        zero_cnt_n = zero_cnt;
        ones_cnt_n = ones_cnt;
        start_n    = 1'b0;
        strobe_n   = 1'b0;
        data_n     = 1'b0;
        end_n      = 1'b0;
        err_n      = 1'b0;

        if (reset_det) begin
            state_n    = ST_IDLE;
            ref_j_n    = 1'b1;
            zero_cnt_n = '0;
            ones_cnt_n = '0;
        end else if (sample) begin
            case (state)
                ST_IDLE: begin
                    if (is_k) begin
                        // The opening K is itself the first SYNC zero.
                        state_n    = ST_SYNC;
                        ref_j_n    = 1'b0;
                        zero_cnt_n = 3'd1;
                    end else begin
                        ref_j_n = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (is_se1) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (is_se0) begin
                        state_n = ST_IDLE;
                    end else begin
                        ref_j_n = is_j;
                        if (!dec_bit) begin
                            if (zero_cnt != 3'd7) zero_cnt_n = zero_cnt + 3'd1;
                        end else if (zero_cnt >= 3'd5) begin
                            state_n    = ST_DATA;
                            start_n    = 1'b1;
                            ones_cnt_n = '0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (is_se1) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (is_se0) begin
                        state_n = ST_EOP;
                    end else begin
                        ref_j_n = is_j;
                        if (ones_cnt == 3'd6) begin
                            ones_cnt_n = '0;
                            if (dec_bit) begin
                                err_n   = 1'b1;
                                state_n = ST_IDLE;
                            end
                        end else begin
                            strobe_n   = 1'b1;
                            data_n     = dec_bit;
                            ones_cnt_n = dec_bit ? ones_cnt + 3'd1 : 3'd0;
                        end
                    end
                end
                ST_EOP: begin
                    if (is_j) begin
                        end_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (!is_se0) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ref_j    <= 1'b1;
            zero_cnt <= '0;
            ones_cnt <= '0;
            start_q  <= 1'b0;
            strobe_q <= 1'b0;
            data_q   <= 1'b0;
            end_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            ref_j    <= ref_j_n;
            zero_cnt <= zero_cnt_n;
            ones_cnt <= ones_cnt_n;
            start_q  <= start_n;
            strobe_q <= strobe_n;
            data_q   <= data_n;
            end_q    <= end_n;
            err_q    <= err_n;
        end
    end

    assign bus.line_state    = line_state;
    assign bus.pkt_start     = start_q;
    assign bus.bit_strobe    = strobe_q;
    assign bus.bit_data      = data_q;
    assign bus.pkt_end       = end_q;
    assign bus.rx_err        = err_q;
    assign bus.usb_reset_det = reset_det;

endmodule

// File: doc/usb_fs_rx_frontend.md
USB_FS_RX_FRONTEND -- requirements
Module: usb_fs_rx_frontend

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 120, meaning consecutive SE0 clocks (2.5 us at 48 MHz) that constitute a bus reset.
REQ-002 SHALL have port clk_48mhz  input  1  sole clock; 4x full-speed bit rate.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port usb_p_rx  input  1  D+ from PHY, asynchronous to clk_48mhz.
REQ-005 SHALL have port usb_n_rx  input  1  D- from PHY, asynchronous to clk_48mhz.
REQ-006 SHALL have port line_state  output  2  synchronized line: 2'b01 J (p=1,n=0), 2'b10 K, 2'b00 SE0, 2'b11 SE1.
REQ-007 SHALL have port pkt_start  output  1  one-cycle pulse when SYNC completes.
REQ-008 SHALL have port bit_strobe  output  1  one-cycle pulse per decoded, unstuffed payload bit.
REQ-009 SHALL have port bit_data  output  1  decoded bit; valid only while bit_strobe=1.
REQ-010 SHALL have port pkt_end  output  1  one-cycle pulse on valid EOP.
REQ-011 SHALL have port rx_err  output  1  one-cycle pulse on stuff error, SE1, or malformed EOP.
REQ-012 SHALL have port usb_reset_det  output  1  level, high while bus reset condition holds.

Function
REQ-013 SHALL pass usb_p_rx/usb_n_rx through a two-flop synchronizer each; line_state is the second-stage value.
REQ-014 SHALL detect a transition in cycle t when line_state(t) != line_state(t-1), and sample at cycle t+2, then every 4 cycles until the next transition (2-bit phase counter, reloaded on every transition).
REQ-015 SHALL NRZI-decode each sample: 1 if sampled J/K equals previous sampled J/K, 0 otherwise.
REQ-016 SHALL implement FSM states IDLE, SYNC, DATA, EOP.
REQ-017 IDLE: first sampled K -> SYNC; J/SE0 samples keep IDLE; previous-sample reference set to J.
REQ-018 SYNC: count decoded 0s (saturating 3-bit); decoded 1 with count >=5 -> DATA and pkt_start; decoded 1 with count <5, or SE0 -> IDLE, no pulse.
REQ-019 SYNC bits SHALL NOT produce bit_strobe.
REQ-020 DATA: each J/K sample yields one decoded bit; ones counter increments on 1, clears on 0.
REQ-021 DATA: bit following six consecutive 1s SHALL be dropped (no bit_strobe) if 0; if 1, rx_err pulses and FSM -> IDLE; ones counter clears after the stuffed bit.
REQ-022 DATA: SE0 sample -> EOP, no bit_strobe.
REQ-023 EOP: further SE0 samples stay; J sample -> pkt_end, IDLE; K sample -> rx_err, IDLE.
REQ-024 SE1 sample in SYNC, DATA or EOP SHALL pulse rx_err and go IDLE; SE1 in IDLE is ignored.
REQ-025 bit_strobe, bit_data, pkt_start, pkt_end, rx_err SHALL be registered, asserted the cycle after the sample point; at most one of pkt_start/bit_strobe/pkt_end/rx_err per cycle.
REQ-026 SE0 counter SHALL count consecutive cycles with line_state=SE0, saturating at RESET_CYCLES, clearing on any non-SE0 cycle.
REQ-027 usb_reset_det SHALL be high from the cycle the counter reaches RESET_CYCLES until the first non-SE0 line_state; while high FSM is forced to IDLE with no rx_err or pkt_end.
REQ-028 Sustained J (e.g. PHY driving during transmit) SHALL hold FSM in IDLE with no output pulses.

Reset
REQ-029 On reset: synchronizer flops and line_state to J (2'b01), FSM IDLE, all counters 0, all pulse outputs 0, usb_reset_det 0.
REQ-030 Reset asserted mid-packet SHALL abort immediately with no pkt_end or rx_err; after release, reception resumes only from a new SYNC.

Verification
REQ-031 Idle J, then KJKJKJKK, then NRZI of 0xA5 LSB-first, SE0 x2 bits, J -> pkt_start once, 8 bit_strobe with bit_data 1,0,1,0,0,1,0,1, pkt_end once, rx_err never.
REQ-032 Payload 0xFF plus stuffed 0 then 0x00 -> 16 bit_strobe (eight 1s, eight 0s), stuffed bit absent.
REQ-033 Payload with seven consecutive 1s (no stuff) -> rx_err one pulse at seventh bit's sample, no pkt_end, FSM IDLE.
REQ-034 SE1 during DATA -> rx_err pulse, no further bit_strobe until next SYNC.
REQ-035 SE0 held 130 cycles -> usb_reset_det rises at cycle 120 of SE0, falls the cycle after line_state returns J; no rx_err.
REQ-036 Bit stream with +/-1 clock edge jitter every transition -> identical decoded bits to REQ-031; reset asserted mid-payload -> no pulses, outputs at reset values.
